// File: rtl/game_step_scheduler.sv
// game_step_scheduler: arbitrates manual and autoplay requests for the single
// 2048 move/fill engine, sequences one engine step per grant, resets the engine
// for new games, counts completed moves and latches game-over / timeout status.
module game_step_scheduler #(
  parameter int INIT_CYCLES    = 2,
  parameter int AUTO_PERIOD    = 50000000,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_req,
  input  logic             auto_en,
  input  logic             new_game,
  input  logic             eng_done,
  input  logic             eng_stuck,
  output logic             eng_rst,
  output logic             eng_run,
  output logic             grant_man,
  output logic             grant_auto,
  output logic             busy,
  output logic             game_over,
  output logic             timeout_err,
  output logic [CNT_W-1:0] move_count,
  output logic [2:0]       state
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int AUTO_W = $clog2(AUTO_PERIOD + 1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_STEP = 3'd2,
    S_OVER = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [AUTO_W-1:0]  auto_cnt_q, auto_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   move_q, move_d;
  logic               pend_man_q, pend_man_d;
  logic               pend_auto_q, pend_auto_d;
  logic               last_auto_q, last_auto_d;
  logic               btn_prev_q, btn_prev_d;
  logic               game_over_q, game_over_d;
  logic               timeout_q, timeout_d;
  logic               grant_man_q, grant_man_d;
  logic               grant_auto_q, grant_auto_d;
  logic               btn_edge, auto_fire, pick_man, pick_auto;

  // Next-state logic: request capture, arbitration and step sequencing.
  always_comb begin
    btn_prev_d   = btn_req;
    btn_edge     = btn_req & ~btn_prev_q;
    auto_fire    = 1'b0;
    auto_cnt_d   = '0;
    if (auto_en) begin
      if (auto_cnt_q == AUTO_W'(AUTO_PERIOD - 1)) begin
        auto_fire = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + 1'b1;
      end
    end

    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    timer_d      = timer_q;
    move_d       = move_q;
    pend_man_d   = pend_man_q;
    pend_auto_d  = pend_auto_q;
    last_auto_d  = last_auto_q;
    game_over_d  = game_over_q;
    timeout_d    = timeout_q;
    grant_man_d  = 1'b0;
    grant_auto_d = 1'b0;
    pick_man     = 1'b0;
    pick_auto    = 1'b0;

    if (new_game) begin
      state_d     = S_INIT;
      init_cnt_d  = '0;
      pend_man_d  = 1'b0;
      pend_auto_d = 1'b0;
      move_d      = '0;
      game_over_d = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          pend_man_d  = 1'b0;
          pend_auto_d = 1'b0;
          if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
            state_d = S_IDLE;
          end else begin
            init_cnt_d = init_cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          // On a tie the side that did not win last time gets the engine.
          pick_man  = pend_man_q & (~pend_auto_q | last_auto_q);
          pick_auto = pend_auto_q & ~pick_man;
          if (pick_man | pick_auto) begin
            state_d      = S_STEP;
            timer_d      = '0;
            grant_man_d  = pick_man;
            grant_auto_d = pick_auto;
            last_auto_d  = pick_auto;
          end
          pend_man_d  = (pend_man_q & ~pick_man) | btn_edge;
          pend_auto_d = auto_en & ((pend_auto_q & ~pick_auto) | auto_fire);
        end
        S_STEP: begin
          timer_d     = timer_q + 1'b1;
          pend_man_d  = pend_man_q | btn_edge;
          pend_auto_d = auto_en & (pend_auto_q | auto_fire);
          // The first STEP cycle still sees the previous step's frozen done flag.
          if ((timer_q != '0) && eng_done) begin
            if (eng_stuck) begin
              state_d     = S_OVER;
              game_over_d = 1'b1;
            end else begin
              state_d = S_IDLE;
              if (move_q != {CNT_W{1'b1}}) move_d = move_q + 1'b1;
            end
          end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = S_ERR;
            timeout_d = 1'b1;
          end
        end
        default: begin
          pend_man_d  = 1'b0;
          pend_auto_d = 1'b0;
        end
      endcase
    end
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      auto_cnt_q   <= '0;
      timer_q      <= '0;
      move_q       <= '0;
      pend_man_q   <= 1'b0;
      pend_auto_q  <= 1'b0;
      last_auto_q  <= 1'b1;
      btn_prev_q   <= 1'b0;
      game_over_q  <= 1'b0;
      timeout_q    <= 1'b0;
      grant_man_q  <= 1'b0;
      grant_auto_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      auto_cnt_q   <= auto_cnt_d;
      timer_q      <= timer_d;
      move_q       <= move_d;
      pend_man_q   <= pend_man_d;
      pend_auto_q  <= pend_auto_d;
      last_auto_q  <= last_auto_d;
      btn_prev_q   <= btn_prev_d;
      game_over_q  <= game_over_d;
      timeout_q    <= timeout_d;
      grant_man_q  <= grant_man_d;
      grant_auto_q <= grant_auto_d;
    end
  end

  assign eng_rst     = (state_q == S_INIT);
  assign eng_run     = (state_q == S_INIT) || (state_q == S_STEP);
  assign busy        = eng_run;
  assign grant_man   = grant_man_q;
  assign grant_auto  = grant_auto_q;
  assign game_over   = game_over_q;
  assign timeout_err = timeout_q;
  assign move_count  = move_q;
  assign state       = state_q;

endmodule

// File: tb/tb_game_step_scheduler.sv
// tb_game_step_scheduler: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the scheduler.
module tb_game_step_scheduler;

  localparam int INIT_CYCLES    = 2;
  localparam int AUTO_PERIOD    = 8;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_W          = 4;
  localparam int CNT_MAX        = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, btn_req, auto_en, new_game, eng_done, eng_stuck;
  logic             eng_rst, eng_run, grant_man, grant_auto, busy;
  logic             game_over, timeout_err;
  logic [CNT_W-1:0] move_count;
  logic [2:0]       state;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0..4, age = cycles spent in current mode,
  // run = consecutive cycles auto_en has been high.
  int m_mode = 0, m_age = 0, m_run = 0, m_moves = 0;
  bit m_pm = 0, m_pa = 0, m_last_auto = 1, m_prev = 0;
  bit m_go = 0, m_to = 0, m_gm = 0, m_ga = 0;

  game_step_scheduler #(
    .INIT_CYCLES(INIT_CYCLES), .AUTO_PERIOD(AUTO_PERIOD),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .btn_req(btn_req), .auto_en(auto_en),
    .new_game(new_game), .eng_done(eng_done), .eng_stuck(eng_stuck),
    .eng_rst(eng_rst), .eng_run(eng_run), .grant_man(grant_man),
    .grant_auto(grant_auto), .busy(busy), .game_over(game_over),
    .timeout_err(timeout_err), .move_count(move_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    bit fire, edge_req, take_man, take_auto;
    if (rst) begin
      m_mode = 0; m_age = 0; m_run = 0; m_moves = 0;
      m_pm = 0; m_pa = 0; m_last_auto = 1; m_prev = 0;
      m_go = 0; m_to = 0; m_gm = 0; m_ga = 0;
      return;
    end
    fire     = auto_en && ((m_run % AUTO_PERIOD) == AUTO_PERIOD - 1);
    edge_req = btn_req && !m_prev;
    m_gm = 0; m_ga = 0;
    if (new_game) begin
      m_mode = 0; m_age = 0; m_pm = 0; m_pa = 0;
      m_moves = 0; m_go = 0; m_to = 0;
    end else if (m_mode == 0) begin
      m_pm = 0; m_pa = 0;
      if (m_age == INIT_CYCLES - 1) begin m_mode = 1; m_age = 0; end
      else m_age++;
    end else if (m_mode == 1) begin
      take_man  = m_pm && (!m_pa || m_last_auto);
      take_auto = m_pa && !take_man;
      if (take_man || take_auto) begin
        m_mode = 2; m_age = 0;
        m_gm = take_man; m_ga = take_auto; m_last_auto = take_auto;
        if (take_man) m_pm = 0;
        if (take_auto) m_pa = 0;
      end
      m_pm = m_pm || edge_req;
      m_pa = auto_en && (m_pa || fire);
    end else if (m_mode == 2) begin
      if (m_age >= 1 && eng_done) begin
        if (eng_stuck) begin m_mode = 3; m_go = 1; end
        else begin m_mode = 1; m_moves = (m_moves < CNT_MAX) ? m_moves + 1 : CNT_MAX; end
        m_age = 0;
      end else if (m_age == TIMEOUT_CYCLES - 1) begin
        m_mode = 4; m_to = 1; m_age = 0;
      end else m_age++;
      m_pm = m_pm || edge_req;
      m_pa = auto_en && (m_pa || fire);
    end else begin
      m_pm = 0; m_pa = 0;
    end
    m_prev = btn_req;
    m_run  = auto_en ? m_run + 1 : 0;
  endtask

  task automatic check_output();
    check_val("state", int'(state), m_mode);
    check_val("eng_rst", int'(eng_rst), int'(m_mode == 0));
    check_val("eng_run", int'(eng_run), int'(m_mode == 0 || m_mode == 2));
    check_val("busy", int'(busy), int'(m_mode == 0 || m_mode == 2));
    check_val("grant_man", int'(grant_man), int'(m_gm));
    check_val("grant_auto", int'(grant_auto), int'(m_ga));
    check_val("game_over", int'(game_over), int'(m_go));
    check_val("timeout_err", int'(timeout_err), int'(m_to));
    check_val("move_count", int'(move_count), m_moves);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_output();
  endtask

  task automatic apply_stimulus();
    btn_req   = ($urandom_range(0, 3) == 0) ? ~btn_req : btn_req;
    if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
    new_game  = ($urandom_range(0, 149) == 0);
    eng_done  = ($urandom_range(0, 4) == 0);
    eng_stuck = ($urandom_range(0, 19) == 0);
    rst       = ($urandom_range(0, 799) == 0);
  endtask

  initial begin
    int n, grants_seen;
    rst = 1; btn_req = 0; auto_en = 0; new_game = 0; eng_done = 0; eng_stuck = 0;
    repeat (3) cycle();
    check_val("reset_state", int'(state), 0);
    check_val("reset_eng_rst", int'(eng_rst), 1);
    rst = 0;
    cycle();
    check_val("init_hold", int'(state), 0);
    cycle();
    check_val("init_done", int'(state), 1);

    // First manual step, engine finishes after six STEP cycles.
    btn_req = 1;
    cycle();
    check_val("pend_idle", int'(state), 1);
    cycle();
    check_val("first_grant", int'(grant_man), 1);
    check_val("first_step", int'(state), 2);
    repeat (5) cycle();
    eng_done = 1;
    cycle();
    eng_done = 0;
    check_val("first_done_state", int'(state), 1);
    check_val("first_done_count", int'(move_count), 1);

    // Held button must not produce further grants.
    grants_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (grant_man) grants_seen++;
    end
    check_val("held_btn_grants", grants_seen, 0);
    check_val("held_btn_count", int'(move_count), 1);

    // Engine never finishes: timeout after TIMEOUT_CYCLES STEP cycles.
    btn_req = 0; cycle();
    btn_req = 1; cycle(); cycle();
    n = 1;
    while (state == 3'd2 && n < 40) begin
      cycle();
      if (state == 3'd2) n++;
    end
    check_val("timeout_len", n, 16);
    check_val("timeout_state", int'(state), 4);
    check_val("timeout_flag", int'(timeout_err), 1);
    check_val("timeout_run", int'(eng_run), 0);

    // New game clears everything.
    btn_req = 0; new_game = 1;
    cycle();
    new_game = 0;
    check_val("newgame_state", int'(state), 0);
    check_val("newgame_err", int'(timeout_err), 0);
    check_val("newgame_count", int'(move_count), 0);
    cycle(); cycle();

    // Done arriving on the timeout cycle wins.
    btn_req = 1; cycle(); cycle();
    repeat (15) cycle();
    eng_done = 1;
    cycle();
    eng_done = 0; btn_req = 0;
    check_val("late_done_state", int'(state), 1);
    check_val("late_done_err", int'(timeout_err), 0);
    check_val("late_done_count", int'(move_count), 1);

    // Randomized traffic with autoplay active most of the time.
    auto_en = 1;
    for (int i = 0; i < 4000; i++) begin
      apply_stimulus();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
